ps2_keycode_decoder: RTL and testbench
======================================

Name: ps2_keycode_decoder

Overview:
Second-generation PS/2 Scan Code Set 2 decoder. It sits between the PS/2 receive byte stream and the character consumer. The block tracks make/break, E0-extended and E1 (Pause) sequences, holds modifier state (Shift, Ctrl, Caps Lock) and produces US-layout ASCII. Characters are buffered in a parametrised FIFO with a valid/ready output, and every key transition is also reported as a one-cycle event.

Parameters:
FIFO_DEPTH, 8, ASCII FIFO entries; power of two, ≥2
CNT_W, $clog2(FIFO_DEPTH+1), occupancy counter width (derived, do not override)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
scan_code  in  8  received byte
valid  in  1  one-cycle strobe, scan_code valid
ascii  out  8  FIFO head character
ascii_valid  out  1  FIFO non-empty
ascii_ready  in  1  consumer pops head when ascii_valid && ascii_ready
evt_valid  out  1  one-cycle key-event strobe
evt_code  out  8  key scan code (prefixes stripped)
evt_ext  out  1  event key was E0-prefixed
evt_break  out  1  1 = release, 0 = press
shift  out  1  lshift|rshift held
ctrl  out  1  ctrl held (0x14 or E0 14)
caps  out  1  caps-lock toggle state
overflow  out  1  one-cycle pulse when a char is dropped (FIFO full)
fill  out  CNT_W  FIFO occupancy

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (async): parser in IDLE; all flags, modifiers and caps 0; FIFO empty; fill=0; ascii=0; ascii_valid, evt_valid and overflow 0.
- Parser FSM. Transitions happen only on valid:
  - IDLE: E0→EXT; F0→BRK; E1→SKIP (skip_cnt=7); else emit make (ext=0)→IDLE.
  - EXT: F0→EXT_BRK; else emit make (ext=1)→IDLE.
  - BRK: emit break (ext=0)→IDLE.
  - EXT_BRK: emit break (ext=1)→IDLE.
  - SKIP: decrement skip_cnt per byte; →IDLE after the 7th byte. No events, no modifier change.
- Emit: evt_valid=1 on the cycle after the completing byte's edge, with evt_code/evt_ext/evt_break registered.
- Ignored codes: E0 12 and E0 59 (fake shifts) produce an event but no modifier change. Code 0x00, 0xAA, 0xFA, 0xFE and 0xEE in IDLE are ignored entirely (no event).
- Modifiers, updated on emit:
  - 0x12 → lshift, 0x59 → rshift; set on make, clear on break.
  - 0x14 or E0 14 → ctrl.
  - 0x58 make toggles caps only if caps_held=0, then sets caps_held; break clears caps_held. Typematic repeat therefore does not re-toggle.
- Character generation on non-extended make only (typematic repeats each generate a char), except E0 5A (keypad Enter → 0x0D) and E0 4A ('/').
  - Letters: uppercase if shift XOR caps.
  - If ctrl: letter → code 0x01–0x1A (caps/shift ignored).
  - Digits/punctuation use the US shifted set when shift=1: 1!2@3#4$5%6^7&8*9(0) -_ =+ [{ ]} \| ;: '" ,< .> /? `~ (0x0E).
  - Space 0x20, Enter 0x0D, Backspace 0x08, Tab 0x09, Esc (0x76) 0x1B.
  - Unmapped codes produce no char.
- Char uses the modifier state before the current byte's update.
- FIFO:
  - Push on the same edge the char is decoded; ascii_valid rises the next cycle (latency 1 cycle from valid to ascii_valid when empty).
  - Push when full is dropped with overflow=1 for one cycle; FIFO contents unchanged. Push and pop in the same cycle while full succeeds, and fill is unchanged.
  - Pop when empty has no effect. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence (e.g. after E0 or within SKIP) returns to IDLE; the partial sequence is discarded.

Optional Feature:
PS2_NUMLOCK_EN
- Defined: adds numlock state, toggled on 0x77 make with the same held-guard as caps. Non-extended keypad codes 70,69,72,7A,6B,73,74,6C,75,7D → '0'–'9' and 71 → '.' when numlock=1. 7C → '*', 7B → '-', 79 → '+' always. Adds output port numlock (1 bit, reset 0).
- Undefined: keypad codes generate no char; 0x77 is a plain event; no numlock port.

Test Plan:
- Bytes 1C, F0 1C → ascii 'a' (0x61) once; events (1C, ext0, brk0) then (1C, ext0, brk1); fill returns 0 after pop.
- 12, 1C, F0 12, 1C → chars 'A' (0x41), then 'a'; shift high then low.
- 58, 58 (repeat), F0 58, 1C → caps=1 after first byte only; char 'A'. Then 58, F0 58, 1C → 'a'.
- E0 4A, E0 F0 4A → '/' once, events with ext=1; E0 12 leaves shift=0.
- E1 14 77 E1 F0 14 F0 77 then 1C → no events during Pause; ctrl=0; char 'a'.
- ascii_ready=0, 9 × 1C with FIFO_DEPTH=8 → fill=8, one overflow pulse. Then push+pop in the same cycle while full → fill stays 8, no overflow.

Source files
------------

// File: rtl/ps2_keycode_decoder.sv
// PS/2 Scan Code Set 2 decoder: make/break/E0/E1 parser, modifier tracking, US ASCII FIFO.
// Optional keypad/numlock support is enabled by defining PS2_NUMLOCK_EN.
module ps2_keycode_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       scan_code,
  input  logic             valid,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic             overflow,
`ifdef PS2_NUMLOCK_EN
  output logic             numlock,
`endif
  output logic [CNT_W-1:0] fill
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       emit, emit_ext, emit_brk, ignored;

  assign ignored = (scan_code == 8'h00) || (scan_code == 8'hAA) || (scan_code == 8'hFA) ||
                   (scan_code == 8'hFE) || (scan_code == 8'hEE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Prefix parser; emit marks the byte that completes a key transition.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    if (valid) begin
      case (state)
        S_IDLE: begin
          if (scan_code == 8'hE0)      state_nxt = S_EXT;
          else if (scan_code == 8'hF0) state_nxt = S_BRK;
          else if (scan_code == 8'hE1) begin
            state_nxt = S_SKIP;
            skip_nxt  = 3'd7;
          end else if (!ignored)       emit = 1'b1;
        end
        S_EXT: begin
          if (scan_code == 8'hF0) state_nxt = S_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          emit      = 1'b1;
          emit_brk  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          emit      = 1'b1;
          emit_ext  = 1'b1;
          emit_brk  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // {hit, alphabet index}
  function automatic logic [5:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return {1'b1, 5'd0};   8'h32: return {1'b1, 5'd1};   8'h21: return {1'b1, 5'd2};
      8'h23: return {1'b1, 5'd3};   8'h24: return {1'b1, 5'd4};   8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};   8'h33: return {1'b1, 5'd7};   8'h43: return {1'b1, 5'd8};
      8'h3B: return {1'b1, 5'd9};   8'h42: return {1'b1, 5'd10};  8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};  8'h31: return {1'b1, 5'd13};  8'h44: return {1'b1, 5'd14};
      8'h4D: return {1'b1, 5'd15};  8'h15: return {1'b1, 5'd16};  8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};  8'h2C: return {1'b1, 5'd19};  8'h3C: return {1'b1, 5'd20};
      8'h2A: return {1'b1, 5'd21};  8'h1D: return {1'b1, 5'd22};  8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};  8'h1A: return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  // {hit, shifted char, plain char}
  function automatic logic [16:0] sym_char(input logic [7:0] c);
    case (c)
      8'h16: return {1'b1, 8'h21, 8'h31};  8'h1E: return {1'b1, 8'h40, 8'h32};
      8'h26: return {1'b1, 8'h23, 8'h33};  8'h25: return {1'b1, 8'h24, 8'h34};
      8'h2E: return {1'b1, 8'h25, 8'h35};  8'h36: return {1'b1, 8'h5E, 8'h36};
      8'h3D: return {1'b1, 8'h26, 8'h37};  8'h3E: return {1'b1, 8'h2A, 8'h38};
      8'h46: return {1'b1, 8'h28, 8'h39};  8'h45: return {1'b1, 8'h29, 8'h30};
      8'h4E: return {1'b1, 8'h5F, 8'h2D};  8'h55: return {1'b1, 8'h2B, 8'h3D};
      8'h54: return {1'b1, 8'h7B, 8'h5B};  8'h5B: return {1'b1, 8'h7D, 8'h5D};
      8'h5D: return {1'b1, 8'h7C, 8'h5C};  8'h4C: return {1'b1, 8'h3A, 8'h3B};
      8'h52: return {1'b1, 8'h22, 8'h27};  8'h41: return {1'b1, 8'h3C, 8'h2C};
      8'h49: return {1'b1, 8'h3E, 8'h2E};  8'h4A: return {1'b1, 8'h3F, 8'h2F};
      8'h0E: return {1'b1, 8'h7E, 8'h60};
      default: return 17'd0;
    endcase
  endfunction

`ifdef PS2_NUMLOCK_EN
  function automatic logic [8:0] keypad_char(input logic [7:0] c, input logic nl);
    case (c)
      8'h7C: return {1'b1, 8'h2A};
      8'h7B: return {1'b1, 8'h2D};
      8'h79: return {1'b1, 8'h2B};
      8'h70: return {nl, 8'h30};  8'h69: return {nl, 8'h31};  8'h72: return {nl, 8'h32};
      8'h7A: return {nl, 8'h33};  8'h6B: return {nl, 8'h34};  8'h73: return {nl, 8'h35};
      8'h74: return {nl, 8'h36};  8'h6C: return {nl, 8'h37};  8'h75: return {nl, 8'h38};
      8'h7D: return {nl, 8'h39};  8'h71: return {nl, 8'h2E};
      default: return 9'd0;
    endcase
  endfunction
  logic [8:0] kp;
  logic       numlock_held, numlock_nxt, numlock_held_nxt;
  assign kp = keypad_char(scan_code, numlock);
`endif

  logic [5:0]  lt;
  logic [16:0] sy;
  logic        chr_ok;
  logic [7:0]  chr;
  assign lt = letter_idx(scan_code);
  assign sy = sym_char(scan_code);

  // Character decode uses the modifier state held before this byte.
  always_comb begin
    chr_ok = 1'b0;
    chr    = 8'h00;
    if (emit && !emit_brk) begin
      if (emit_ext) begin
        if (scan_code == 8'h5A)      begin chr_ok = 1'b1; chr = 8'h0D; end
        else if (scan_code == 8'h4A) begin chr_ok = 1'b1; chr = 8'h2F; end
      end else if (lt[5]) begin
        chr_ok = 1'b1;
        if (ctrl)               chr = 8'(lt[4:0]) + 8'd1;
        else if (shift ^ caps)  chr = 8'h41 + 8'(lt[4:0]);
        else                    chr = 8'h61 + 8'(lt[4:0]);
      end else if (sy[16]) begin
        chr_ok = 1'b1;
        chr    = shift ? sy[15:8] : sy[7:0];
      end else begin
        case (scan_code)
          8'h29: begin chr_ok = 1'b1; chr = 8'h20; end
          8'h5A: begin chr_ok = 1'b1; chr = 8'h0D; end
          8'h66: begin chr_ok = 1'b1; chr = 8'h08; end
          8'h0D: begin chr_ok = 1'b1; chr = 8'h09; end
          8'h76: begin chr_ok = 1'b1; chr = 8'h1B; end
          default: begin
`ifdef PS2_NUMLOCK_EN
            chr_ok = kp[8];
            chr    = kp[7:0];
`endif
          end
        endcase
      end
    end
  end

  logic lshift, rshift, caps_held;
  logic lshift_nxt, rshift_nxt, ctrl_nxt, caps_nxt, caps_held_nxt;

  // Modifier updates; E0 12 / E0 59 are fake shifts and leave shift untouched.
  always_comb begin
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    ctrl_nxt      = ctrl;
    caps_nxt      = caps;
    caps_held_nxt = caps_held;
`ifdef PS2_NUMLOCK_EN
    numlock_nxt      = numlock;
    numlock_held_nxt = numlock_held;
`endif
    if (emit) begin
      if (!emit_ext && scan_code == 8'h12) lshift_nxt = !emit_brk;
      if (!emit_ext && scan_code == 8'h59) rshift_nxt = !emit_brk;
      if (scan_code == 8'h14)              ctrl_nxt   = !emit_brk;
      if (!emit_ext && scan_code == 8'h58) begin
        if (!emit_brk && !caps_held) caps_nxt = !caps;
        caps_held_nxt = !emit_brk;
      end
`ifdef PS2_NUMLOCK_EN
      if (!emit_ext && scan_code == 8'h77) begin
        if (!emit_brk && !numlock_held) numlock_nxt = !numlock;
        numlock_held_nxt = !emit_brk;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      shift     <= 1'b0;
      ctrl      <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_break <= 1'b0;
`ifdef PS2_NUMLOCK_EN
      numlock      <= 1'b0;
      numlock_held <= 1'b0;
`endif
    end else begin
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      shift     <= lshift_nxt | rshift_nxt;
      ctrl      <= ctrl_nxt;
      caps      <= caps_nxt;
      caps_held <= caps_held_nxt;
      evt_valid <= emit;
      if (emit) begin
        evt_code  <= scan_code;
        evt_ext   <= emit_ext;
        evt_break <= emit_brk;
      end
`ifdef PS2_NUMLOCK_EN
      numlock      <= numlock_nxt;
      numlock_held <= numlock_held_nxt;
`endif
    end
  end

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic             pop, full, push_ok, drop;
  logic [CNT_W-1:0] fill_nxt;
  logic [7:0]       head_nxt;

  assign pop     = ascii_valid && ascii_ready;
  assign full    = (fill == CNT_W'(FIFO_DEPTH));
  assign push_ok = chr_ok && (!full || pop);
  assign drop    = chr_ok && full && !pop;
  assign rd_nxt  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // Registered head: a push landing in the slot that becomes the head bypasses the array.
  always_comb begin
    fill_nxt = fill;
    if (push_ok && !pop)      fill_nxt = fill + CNT_W'(1);
    else if (!push_ok && pop) fill_nxt = fill - CNT_W'(1);
    head_nxt = (push_ok && wr_ptr == rd_nxt) ? chr : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= chr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      ascii       <= 8'h00;
      ascii_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_nxt;
      fill        <= fill_nxt;
      ascii       <= head_nxt;
      ascii_valid <= (fill_nxt != '0);
      overflow    <= drop;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Scoreboard bench for ps2_keycode_decoder: pattern-matching byte model feeds expected
// event/char queues, an independent negedge monitor pops and compares.
module tb_ps2_keycode_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    scan_code = 8'h00;
  logic          valid = 1'b0;
  logic [7:0]    ascii;
  logic          ascii_valid;
  logic          ascii_ready = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext, evt_break, shift, ctrl, caps, overflow;
  logic [CW-1:0] fill;
`ifdef PS2_NUMLOCK_EN
  logic          numlock;
`endif

  ps2_keycode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scan_code(scan_code), .valid(valid),
    .ascii(ascii), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .shift(shift), .ctrl(ctrl), .caps(caps), .overflow(overflow),
`ifdef PS2_NUMLOCK_EN
    .numlock(numlock),
`endif
    .fill(fill)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] code; logic ext; logic brk; } evt_t;

  evt_t       exp_evt[$];
  logic [7:0] exp_chr[$];
  logic [7:0] pend[$];
  int         checks = 0, failures = 0;
  int         cnt = 0;
  bit         ovf_exp = 0, push_now = 0, run = 0, rdy = 0;
  logic [7:0] push_ch = 8'h00;
  bit         m_ls = 0, m_rs = 0, m_ctrl = 0, m_caps = 0, m_caps_held = 0;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
                                 8'h49, 8'h4A, 8'h0E};
  logic [7:0] sym_lo [21]    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h30, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
                                 8'h2E, 8'h2F, 8'h60};
  logic [7:0] sym_hi [21]    = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28,
                                 8'h29, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
                                 8'h3E, 8'h3F, 8'h7E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // US-layout character for a key press, given the modifiers held before it.
  task automatic model_char(input logic [7:0] c, input bit ext, output bit ok, output logic [7:0] ch);
    ok = 0;
    ch = 8'h00;
    if (ext) begin
      if (c == 8'h5A) begin ok = 1; ch = 8'h0D; end
      if (c == 8'h4A) begin ok = 1; ch = 8'h2F; end
      return;
    end
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == c) begin
        ok = 1;
        if (m_ctrl)                  ch = 8'(i + 1);
        else if ((m_ls || m_rs) ^ m_caps) ch = 8'(65 + i);
        else                         ch = 8'(97 + i);
        return;
      end
    for (int i = 0; i < 21; i++)
      if (sym_codes[i] == c) begin
        ok = 1;
        ch = (m_ls || m_rs) ? sym_hi[i] : sym_lo[i];
        return;
      end
    ok = 1;
    case (c)
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      8'h0D: ch = 8'h09;
      8'h76: ch = 8'h1B;
      default: ok = 0;
    endcase
  endtask

  task automatic model_emit(input logic [7:0] c, input bit ext, input bit brk);
    bit ok;
    logic [7:0] ch;
    exp_evt.push_back('{code: c, ext: ext, brk: brk});
    if (!brk) begin
      model_char(c, ext, ok, ch);
      if (ok) begin push_now = 1; push_ch = ch; end
    end
    if (!ext && c == 8'h12) m_ls = !brk;
    if (!ext && c == 8'h59) m_rs = !brk;
    if (c == 8'h14) m_ctrl = !brk;
    if (!ext && c == 8'h58) begin
      if (!brk && !m_caps_held) m_caps = !m_caps;
      m_caps_held = !brk;
    end
    pend.delete();
  endtask

  // Recognises complete byte patterns: x | F0 x | E0 x | E0 F0 x | E1 + 7 bytes.
  task automatic model_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend[0] == 8'hE1) begin
      if (pend.size() == 8) pend.delete();
      return;
    end
    if (pend.size() == 1) begin
      if (b == 8'hE0 || b == 8'hF0) return;
      if (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) begin
        pend.delete();
        return;
      end
      model_emit(b, 0, 0);
    end else if (pend.size() == 2) begin
      if (pend[0] == 8'hF0) model_emit(b, 0, 1);
      else if (b != 8'hF0) model_emit(b, 1, 0);
    end else begin
      model_emit(b, 1, 1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_code   = b;
    valid       = 1'b1;
    ascii_ready = rdy;
    model_byte(b);
    @(posedge clk);
    #1;
    valid    = 1'b0;
    push_now = 0;
    chk("shift", shift, m_ls || m_rs);
    chk("ctrl", ctrl, m_ctrl);
    chk("caps", caps, m_caps);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid       = 1'b0;
      ascii_ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 0;
    exp_evt.delete(); exp_chr.delete(); pend.delete();
    cnt = 0; ovf_exp = 0; push_now = 0;
    m_ls = 0; m_rs = 0; m_ctrl = 0; m_caps = 0; m_caps_held = 0;
    idle(2);
    chk("rst_fill", fill, 0);
    chk("rst_ascii", ascii, 0);
    chk("rst_ascii_valid", ascii_valid, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_mods", {shift, ctrl, caps}, 0);
    rst = 1'b0;
    run = 1;
  endtask

  // Monitor: compares DUT outputs against the queues, then advances model FIFO occupancy.
  always @(negedge clk) begin
    if (run && !rst) begin
      evt_t e;
      chk("fill", fill, cnt);
      chk("ascii_valid", ascii_valid, cnt != 0);
      chk("overflow", overflow, ovf_exp);
      if (evt_valid) begin
        if (exp_evt.size() == 0) chk("unexpected_evt", {evt_code, evt_ext, evt_break}, 0);
        else begin
          e = exp_evt.pop_front();
          chk("evt", {evt_code, evt_ext, evt_break}, {e.code, e.ext, e.brk});
        end
      end
      chk("evt_backlog", exp_evt.size() > 1, 0);
      if (cnt > 0 && ascii_ready) begin
        chk("ascii", ascii, exp_chr.pop_front());
        cnt--;
      end
      ovf_exp = 0;
      if (push_now) begin
        if (cnt == DEPTH) ovf_exp = 1;
        else begin
          exp_chr.push_back(push_ch);
          cnt++;
        end
      end
    end
  end

  typedef struct packed { logic [7:0] code; logic ext; } key_t;
  key_t pool[$] = '{'{8'h1C, 0}, '{8'h32, 0}, '{8'h1A, 0}, '{8'h4D, 0}, '{8'h16, 0}, '{8'h1E, 0},
                    '{8'h4E, 0}, '{8'h52, 0}, '{8'h4A, 0}, '{8'h0E, 0}, '{8'h5D, 0}, '{8'h12, 0},
                    '{8'h59, 0}, '{8'h14, 0}, '{8'h58, 0}, '{8'h14, 1}, '{8'h12, 1}, '{8'h59, 1},
                    '{8'h4A, 1}, '{8'h5A, 1}, '{8'h29, 0}, '{8'h5A, 0}, '{8'h66, 0}, '{8'h0D, 0},
                    '{8'h76, 0}, '{8'hAA, 0}, '{8'h05, 0}, '{8'h75, 1}};

  task automatic pause_seq();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
  endtask

  initial begin
    do_reset();
    rdy = 1;

    // a press/release, drained
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    idle(3);
    chk("tp1_fill_zero", fill, 0);

    // shifted letter then plain
    send_byte(8'h12);
    chk("tp2_shift_on", shift, 1);
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    chk("tp2_shift_off", shift, 0);
    send_byte(8'h1C);
    idle(3);

    // caps toggle with typematic repeat
    send_byte(8'h58);
    chk("tp3_caps_on", caps, 1);
    send_byte(8'h58);
    chk("tp3_caps_repeat", caps, 1);
    send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    chk("tp3_caps_off", caps, 0);
    send_byte(8'h1C);
    idle(3);

    // extended slash and fake shift
    send_byte(8'hE0); send_byte(8'h4A); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h4A);
    send_byte(8'hE0); send_byte(8'h12);
    chk("tp4_fake_shift", shift, 0);
    idle(3);

    // pause sequence then a letter
    pause_seq();
    chk("tp5_ctrl", ctrl, 0);
    send_byte(8'h1C);
    idle(3);

    // fill to full, overflow, then simultaneous push+pop while full
    rdy = 0;
    repeat (9) send_byte(8'h1C);
    idle(1);
    chk("tp6_full", fill, DEPTH);
    rdy = 1;
    send_byte(8'h1C);
    rdy = 0;
    idle(1);
    chk("tp6_full_pushpop", fill, DEPTH);
    chk("tp6_no_ovf", overflow, 0);
    rdy = 1;
    idle(DEPTH + 2);
    send_byte(8'hF0); send_byte(8'h1C);

    // reset in the middle of an E0 prefix and inside a pause sequence
    send_byte(8'hE0);
    do_reset();
    rdy = 1;
    send_byte(8'h1C);
    send_byte(8'hE1); send_byte(8'h14);
    do_reset();
    rdy = 1;
    send_byte(8'h32);
    idle(3);

    // randomized key activity with random consumer backpressure
    for (int n = 0; n < 400; n++) begin
      key_t k;
      k   = pool[$urandom_range(0, pool.size() - 1)];
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) pause_seq();
      else begin
        if (k.ext) send_byte(8'hE0);
        if ($urandom_range(0, 9) < 3) send_byte(8'hF0);
        send_byte(k.code);
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    rdy = 1;
    idle(DEPTH + 4);
    chk("end_chr_queue", exp_chr.size(), 0);
    chk("end_evt_queue", exp_evt.size(), 0);
    chk("end_fill", fill, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
